// File: rtl/tt_proj_mux_ctrl_if.sv
// Project-select request handshake between the host sequencer and the mux controller.
interface tt_proj_mux_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ready;

  modport master (output sel_valid, output sel_addr, input  sel_ready);
  modport slave  (input  sel_valid, input  sel_addr, output sel_ready);
endinterface

// File: rtl/tt_proj_mux_ctrl.sv
// Multi-project select/routing stage: one-hot enable, broadcast pad word with a
// timed forced reset after each switch, and registered return of the active project's outputs.
module tt_proj_mux_ctrl #(
  parameter int N_PROJ     = 8,
  parameter int ADDR_W     = 5,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_proj_mux_ctrl_if.slave     sel,
  input  logic [17:0]           pad_in,
  output logic [17:0]           iw,
  output logic [N_PROJ-1:0]     ena,
  input  logic [24*N_PROJ-1:0]  ow_all,
  output logic [23:0]           pad_out,
  output logic                  active,
  output logic [ADDR_W-1:0]     cur_addr
);

  typedef enum logic [1:0] {IDLE, DRAIN, HOLD, RUN} state_t;

  localparam logic [ADDR_W:0] N_PROJ_W = (ADDR_W+1)'(N_PROJ);
  localparam logic [7:0]      RST_LOAD = 8'(RST_CYCLES);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          cnt, cnt_n;
  logic                req_ok, req_ok_n;
  logic                ready, accept, in_range;
  logic [N_PROJ-1:0]   ena_n;
  logic [23:0]         ow_sel;

  assign ready         = (state == IDLE) || (state == RUN);
  assign sel.sel_ready = ready;
  assign accept        = sel.sel_valid && ready;
  assign in_range      = {1'b0, sel.sel_addr} < N_PROJ_W;
  assign active        = (state == RUN);

  always_comb begin
    state_n  = state;
    addr_n   = cur_addr;
    cnt_n    = cnt;
    req_ok_n = req_ok;
    unique case (state)
      IDLE: begin
        if (accept && in_range) begin
          addr_n   = sel.sel_addr;
          req_ok_n = 1'b1;
          state_n  = DRAIN;
        end
      end
      RUN: begin
        if (accept) begin
          req_ok_n = in_range;
          if (in_range) addr_n = sel.sel_addr;
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        if (req_ok) begin
          cnt_n   = RST_LOAD;
          state_n = HOLD;
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // Enable is computed from the next state/address so the register never holds two bits.
  always_comb begin
    ena_n = '0;
    for (int unsigned k = 0; k < N_PROJ; k++) begin
      ena_n[k] = ((state_n == HOLD) || (state_n == RUN)) && (addr_n == ADDR_W'(k));
    end
  end

  always_comb begin
    ow_sel = '0;
    for (int unsigned k = 0; k < N_PROJ; k++) begin
      if (cur_addr == ADDR_W'(k)) ow_sel = ow_all[24*k +: 24];
    end
  end

  always_comb begin
    iw    = '0;
    iw[0] = pad_in[0];
    iw[1] = pad_in[1] && (state == RUN);
    if ((state == HOLD) || (state == RUN)) iw[17:2] = pad_in[17:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      cnt      <= '0;
      req_ok   <= 1'b0;
      ena      <= '0;
      pad_out  <= '0;
    end else begin
      state    <= state_n;
      cur_addr <= addr_n;
      cnt      <= cnt_n;
      req_ok   <= req_ok_n;
      ena      <= ena_n;
      // Only capture while staying in RUN, so the first DRAIN cycle already reads zero.
      pad_out  <= ((state == RUN) && (state_n == RUN)) ? ow_sel : '0;
    end
  end

endmodule
